q_sample_ctrl: RTL and testbench

- Synchronous controller that drives the clock input of a q_flop and samples its result over the ack/out handshake.
- Acts as the clocked initiator in place of the free-running inverter-delay clock loop.
- Downstream synchronous logic requests samples, and receives resolved bits on a valid/ready interface.
- Resolution is bounded by a timeout, and every sample is counted.

---
 rtl/q_sample_ctrl.sv | 148 ++++++++++++++
 tb/tb_q_sample_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_sample_ctrl.sv
// q_sample_ctrl: clocked initiator for a q_flop resolver. Drives q_clk, waits on the
// synchronized ack/out handshake and hands each resolved bit to a valid/ready consumer.
module q_sample_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req,
  output logic             q_clk,
  input  logic             q_ack,
  input  logic             q_out,
  output logic             res_valid,
  output logic             res_data,
  output logic             res_err,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_WAIT_RES,
    ST_RELEASE,
    ST_WAIT_IDLE,
    ST_OUTPUT
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] out_sync_q, out_sync_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;
  logic                   res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   res_valid_q, res_valid_d;
  logic                   q_clk_q, q_clk_d;
  logic                   ack_s, out_s;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign out_s = out_sync_q[SYNC_STAGES-1];

  // State register: every flop of the block, including the synchronizer chains.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q       <= ST_IDLE;
      ack_sync_q    <= '1;
      out_sync_q    <= '1;
      timer_q       <= '0;
      sample_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      res_data_q    <= 1'b0;
      res_err_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      q_clk_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      ack_sync_q    <= ack_sync_d;
      out_sync_q    <= out_sync_d;
      timer_q       <= timer_d;
      sample_cnt_q  <= sample_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      res_data_q    <= res_data_d;
      res_err_q     <= res_err_d;
      res_valid_q   <= res_valid_d;
      q_clk_q       <= q_clk_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    ack_sync_d    = {ack_sync_q[SYNC_STAGES-2:0], q_ack};
    out_sync_d    = {out_sync_q[SYNC_STAGES-2:0], q_out};
    state_d       = state_q;
    timer_d       = timer_q;
    sample_cnt_d  = sample_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    res_data_d    = res_data_q;
    res_err_d     = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req && ack_s) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        timer_d = '0;
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        // A resolution seen on the last timer cycle still counts as a good sample.
        if (!ack_s) begin
          res_data_d = out_s;
          res_err_d  = 1'b0;
          state_d    = ST_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          res_data_d = 1'b0;
          res_err_d  = 1'b1;
          state_d    = ST_RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        timer_d = '0;
        state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (ack_s) begin
          state_d = ST_OUTPUT;
        end else if (timer_q == TIMER_LAST) begin
          res_err_d = 1'b1;
          state_d   = ST_OUTPUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          state_d      = ST_IDLE;
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (res_err_q && (timeout_cnt_q != CNT_MAX)) timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: q_clk follows the current state one cycle later, res_valid tracks OUTPUT.
  always_comb begin
    q_clk_d     = !((state_q == ST_SAMPLE) || (state_q == ST_WAIT_RES));
    res_valid_d = (state_d == ST_OUTPUT);
  end

  assign q_clk       = q_clk_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign sample_cnt  = sample_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_q_sample_ctrl.sv
// Testbench for q_sample_ctrl: q_flop behavioural model, directed vector table,
// multi-cycle corner sequences and randomized samples against an outcome-level reference.
module tb_q_sample_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;
  localparam int CNT_W       = 4;
  localparam int CNT_MOD     = 1 << CNT_W;
  localparam int CNT_SAT     = CNT_MOD - 1;
  localparam int NEVER       = -1;
  localparam int SLOW_RISE   = 30;
  // Last resolver delays (cycles after the q_clk edge) still inside the timeout window.
  localparam int FALL_EDGE   = TIMEOUT - 1 - SYNC_STAGES;
  localparam int RISE_EDGE   = TIMEOUT - 1 - SYNC_STAGES;
  localparam int MIN_LAT     = 5 + 2 * SYNC_STAGES;
  localparam int WAIT_LIMIT  = 200;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             req = 1'b0;
  logic             q_ack = 1'b1;
  logic             q_out = 1'b0;
  logic             res_ready = 1'b0;
  logic             q_clk, res_valid, res_data, res_err, busy;
  logic [CNT_W-1:0] sample_cnt, timeout_cnt;

  int checks = 0;
  int errors = 0;
  int exp_sample = 0;
  int exp_to = 0;

  always #5 clk = ~clk;

  q_sample_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req        (req),
    .q_clk      (q_clk),
    .q_ack      (q_ack),
    .q_out      (q_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_ready  (res_ready),
    .busy       (busy),
    .sample_cnt (sample_cnt),
    .timeout_cnt(timeout_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // q_flop model knobs and bus monitor state
  int   fall_delay = NEVER;
  int   rise_delay = 0;
  bit   out_val = 1'b0;
  bit   ack_force = 1'b0;
  bit   ack_force_val = 1'b1;
  int   phase = 0;
  logic q_clk_prev = 1'b1;
  int   hs_cnt = 0;
  int   fall_cnt = 0;
  int   low_run = 0;
  int   last_low = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_data = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (q_clk === 1'b0) low_run++;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
    if (q_clk_prev === 1'b1 && q_clk === 1'b0) fall_cnt++;
    if (prev_valid && !prev_ready) begin
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, prev_data);
      check("hold_err", res_err, prev_err);
    end
    if (res_valid && res_ready) hs_cnt++;
    prev_valid = res_valid;
    prev_ready = res_ready;
    prev_data  = res_data;
    prev_err   = res_err;

    // Resolver: answers fall_delay cycles after q_clk falls, idles rise_delay after it rises.
    if (q_clk !== q_clk_prev) phase = 0;
    else phase++;
    q_clk_prev = q_clk;
    if (ack_force) q_ack = ack_force_val;
    else if (q_clk === 1'b0) begin
      if (fall_delay != NEVER && phase >= fall_delay) begin
        q_ack = 1'b0;
        q_out = out_val;
      end
    end else if (phase >= rise_delay) begin
      q_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a sample errs if the resolver never answers or never returns idle in time.
  function automatic void ref_outcome(input int fall, input int rise, input bit ov,
                                      output bit data, output bit err);
    bit resolved, returned;
    resolved = (fall != NEVER);
    returned = !resolved || (rise < SLOW_RISE);
    data = resolved ? ov : 1'b0;
    err  = !resolved || !returned;
  endfunction

  task automatic run_sample(input string name, input int fall, input int rise, input bit ov,
                            input int rdy, input bit exp_data, input bit exp_err);
    int n_busy, n_valid, hs0;
    fall_delay = fall;
    rise_delay = rise;
    out_val    = ov;
    hs0        = hs_cnt;
    req        = 1'b1;
    n_busy     = 0;
    do begin
      tick();
      n_busy++;
    end while (!busy && n_busy < WAIT_LIMIT);
    check({name, "_start"}, busy, 1);
    req     = 1'b0;
    n_valid = 0;
    while (!res_valid && n_valid < WAIT_LIMIT) begin
      tick();
      n_valid++;
    end
    check({name, "_valid"}, res_valid, 1);
    check({name, "_latmin"}, (n_busy + n_valid) >= MIN_LAT, 1);
    check({name, "_qclk_high"}, q_clk, 1);
    check({name, "_data"}, res_data, exp_data);
    check({name, "_err"}, res_err, exp_err);
    repeat (rdy) tick();
    res_ready = 1'b1;
    tick();
    res_ready  = 1'b0;
    exp_sample = (exp_sample + 1) % CNT_MOD;
    if (exp_err && exp_to < CNT_SAT) exp_to++;
    $display("sample %s: fall=%0d rise=%0d data=%0d err=%0d cnt=%0d to=%0d",
             name, fall, rise, res_data, res_err, sample_cnt, timeout_cnt);
    check({name, "_drop"}, res_valid, 0);
    check({name, "_xfers"}, hs_cnt - hs0, 1);
    check({name, "_scnt"}, sample_cnt, exp_sample);
    check({name, "_tcnt"}, timeout_cnt, exp_to);
  endtask

  typedef struct {
    string name;
    int    fall;
    int    rise;
    bit    ov;
    int    rdy;
    bit    exp_data;
    bit    exp_err;
    int    exp_low;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, hs0, f0;
    int fall, rise, rdy;
    bit ov, e_data, e_err;

    vecs[0] = '{"res_one",   3,             0,             1'b1, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{"hold_zero", 3,             0,             1'b0, 5, 1'b0, 1'b0, 0};
    vecs[2] = '{"timeout",   NEVER,         0,             1'b1, 0, 1'b0, 1'b1, TIMEOUT + 1};
    vecs[3] = '{"res_edge",  FALL_EDGE,     1,             1'b1, 0, 1'b1, 1'b0, 0};
    vecs[4] = '{"res_late",  FALL_EDGE + 1, 1,             1'b1, 0, 1'b0, 1'b1, TIMEOUT + 1};
    vecs[5] = '{"idle_edge", 0,             RISE_EDGE,     1'b1, 1, 1'b1, 1'b0, 0};
    vecs[6] = '{"idle_late", 0,             RISE_EDGE + 1, 1'b1, 1, 1'b1, 1'b1, 0};
    vecs[7] = '{"res_quick", 0,             0,             1'b0, 2, 1'b0, 1'b0, 0};

    repeat (3) tick();
    check("rst_qclk", q_clk, 1);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_scnt", sample_cnt, 0);
    check("rst_tcnt", timeout_cnt, 0);
    rst_l = 1'b1;
    repeat (4) tick();

    foreach (vecs[i]) begin
      run_sample(vecs[i].name, vecs[i].fall, vecs[i].rise, vecs[i].ov, vecs[i].rdy,
                 vecs[i].exp_data, vecs[i].exp_err);
      if (vecs[i].exp_low != 0) check({vecs[i].name, "_lowlen"}, last_low, vecs[i].exp_low);
      repeat (TIMEOUT + 4) tick();
    end

    // Reset in the middle of WAIT_RES
    fall_delay = NEVER;
    req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!busy && n < WAIT_LIMIT);
    req = 1'b0;
    repeat (5) tick();
    check("midrst_pre_qclk", q_clk, 0);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    check("midrst_qclk", q_clk, 1);
    check("midrst_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_scnt", sample_cnt, 0);
    check("midrst_tcnt", timeout_cnt, 0);
    exp_sample = 0;
    exp_to     = 0;
    repeat (4) tick();
    run_sample("after_rst", 2, 1, 1'b1, 0, 1'b1, 1'b0);

    // req held high with res_ready high: four back-to-back samples
    fall_delay = 1;
    rise_delay = 1;
    out_val    = 1'b1;
    res_ready  = 1'b1;
    hs0 = hs_cnt;
    f0  = fall_cnt;
    req = 1'b1;
    n   = 0;
    while ((hs_cnt - hs0) < 4 && n < 8 * WAIT_LIMIT) begin
      tick();
      n++;
    end
    req = 1'b0;
    repeat (TIMEOUT) tick();
    res_ready  = 1'b0;
    exp_sample = (exp_sample + 4) % CNT_MOD;
    $display("burst: pulses=%0d q_clk_falls=%0d cnt=%0d", hs_cnt - hs0, fall_cnt - f0, sample_cnt);
    check("burst_pulses", hs_cnt - hs0, 4);
    check("burst_falls", fall_cnt - f0, 4);
    check("burst_scnt", sample_cnt, exp_sample);
    check("burst_idle", busy, 0);

    // q_ack low in IDLE blocks a request until it rises
    ack_force_val = 1'b0;
    ack_force     = 1'b1;
    repeat (SYNC_STAGES + 2) tick();
    f0  = fall_cnt;
    req = 1'b1;
    repeat (10) tick();
    check("blocked_busy", busy, 0);
    check("blocked_falls", fall_cnt - f0, 0);
    ack_force = 1'b0;
    run_sample("unblocked", 1, 0, 1'b0, 0, 1'b0, 1'b0);

    // Randomized samples against the outcome reference
    for (int k = 0; k < 40; k++) begin
      fall = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 6));
      rise = ($urandom_range(0, 4) == 0) ? SLOW_RISE : int'($urandom_range(0, 5));
      ov   = 1'($urandom_range(0, 1));
      rdy  = int'($urandom_range(0, 3));
      ref_outcome(fall, rise, ov, e_data, e_err);
      run_sample($sformatf("rnd%0d", k), fall, rise, ov, rdy, e_data, e_err);
    end

    // Drive timeout_cnt into saturation
    for (int k = 0; k < CNT_SAT + 2; k++) begin
      run_sample($sformatf("sat%0d", k), NEVER, 0, 1'b0, 0, 1'b0, 1'b1);
    end
    check("sat_final", timeout_cnt, CNT_SAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
